// File: rtl/seq_detector.sv
// Serial pattern detector: shifts qualified bits into a PAT_W-bit window and
// pulses detect one clock after the window completes PATTERN. It also keeps a
// saturating match count.
module seq_detector #(
  parameter int             PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter bit             OVERLAP = 1'b1,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_count,
  output logic             detect,
  output logic [PAT_W-1:0] window,
  output logic [CNT_W-1:0] match_count,
  output logic             cnt_sat
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic [FILL_W-1:0] fill;
  logic [FILL_W-1:0] fill_next;
  logic [PAT_W-1:0]  window_next;
  logic [CNT_W-1:0]  count_next;
  logic              match;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    window_next = window;
    fill_next   = fill;
    match       = 1'b0;
    if (din_valid) begin
      window_next = {window[PAT_W-2:0], din};
      fill_next   = (fill == FILL_FULL) ? fill : fill + FILL_W'(1);
      // The fill qualifier keeps an all-zero pattern from matching the reset window.
      match       = (fill_next == FILL_FULL) && (window_next == PATTERN);
      if (!OVERLAP && match) begin
        fill_next = '0;
      end
    end

    count_next = match_count;
    if (clr_count) begin
      count_next = '0;
    end else if (match && (match_count != CNT_MAX)) begin
      count_next = match_count + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      window      <= '0;
      fill        <= '0;
      detect      <= 1'b0;
      match_count <= '0;
      cnt_sat     <= 1'b0;
    end else begin
      window      <= window_next;
      fill        <= fill_next;
      detect      <= match;
      match_count <= count_next;
      cnt_sat     <= (count_next == CNT_MAX);
    end
  end

endmodule

// File: tb/tb_seq_detector.sv
// Directed bench for seq_detector: several parameterisations share one
// stimulus stream and are checked against hand-computed expectations.
module tb_seq_detector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din = 1'b0;
  logic din_valid = 1'b0;
  logic clr_count = 1'b0;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  // Default configuration: PATTERN 1011, overlapping.
  logic       det_ovl;
  logic [3:0] win_ovl;
  logic [7:0] cnt_ovl;
  logic       sat_ovl;
  seq_detector u_ovl (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .detect(det_ovl), .window(win_ovl), .match_count(cnt_ovl), .cnt_sat(sat_ovl)
  );

  // Non-overlapping.
  logic       det_novl;
  logic [3:0] win_novl;
  logic [7:0] cnt_novl;
  logic       sat_novl;
  seq_detector #(.OVERLAP(1'b0)) u_novl (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .detect(det_novl), .window(win_novl), .match_count(cnt_novl), .cnt_sat(sat_novl)
  );

  // Periodic pattern 1111.
  logic       det_ones;
  logic [3:0] win_ones;
  logic [7:0] cnt_ones;
  logic       sat_ones;
  seq_detector #(.PATTERN(4'b1111)) u_ones (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .detect(det_ones), .window(win_ones), .match_count(cnt_ones), .cnt_sat(sat_ones)
  );

  // All-zero pattern.
  logic       det_zero;
  logic [3:0] win_zero;
  logic [7:0] cnt_zero;
  logic       sat_zero;
  seq_detector #(.PATTERN(4'b0000)) u_zero (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .detect(det_zero), .window(win_zero), .match_count(cnt_zero), .cnt_sat(sat_zero)
  );

  // Narrow counter for saturation.
  logic       det_sat;
  logic [3:0] win_sat;
  logic [1:0] cnt_sat2;
  logic       sat_sat;
  seq_detector #(.CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .clr_count(clr_count),
    .detect(det_sat), .window(win_sat), .match_count(cnt_sat2), .cnt_sat(sat_sat)
  );

  // Apply inputs, take one rising edge, return 1 time unit later for sampling.
  task automatic step(input logic v, input logic b, input logic c);
    din_valid = v;
    din       = b;
    clr_count = c;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    total_cnt++;
    if ({det_ovl, win_ovl, cnt_ovl, sat_ovl} !== 14'd0) begin
      $display("FAIL reset_ovl: got det=%b win=%b cnt=%0d sat=%b, want all zero",
               det_ovl, win_ovl, cnt_ovl, sat_ovl);
    end else pass_cnt++;
    total_cnt++;
    if ({det_sat, win_sat, cnt_sat2, sat_sat} !== 8'd0) begin
      $display("FAIL reset_sat: got det=%b win=%b cnt=%0d sat=%b, want all zero",
               det_sat, win_sat, cnt_sat2, sat_sat);
    end else pass_cnt++;
  endtask

  task automatic test_overlap();
    logic [6:0] bits     = 7'b1011011;  // sent MSB first
    logic [6:0] exp_ovl  = 7'b0001001;
    logic [6:0] exp_novl = 7'b0001000;
    do_reset();
    for (int i = 6; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0);
      total_cnt++;
      if (det_ovl !== exp_ovl[i]) begin
        $display("FAIL overlap_detect bit%0d: got %b want %b", 7 - i, det_ovl, exp_ovl[i]);
      end else pass_cnt++;
      total_cnt++;
      if (det_novl !== exp_novl[i]) begin
        $display("FAIL nonoverlap_detect bit%0d: got %b want %b", 7 - i, det_novl, exp_novl[i]);
      end else pass_cnt++;
    end
    total_cnt++;
    if (cnt_ovl !== 8'd2 || win_ovl !== 4'b1011) begin
      $display("FAIL overlap_end: got cnt=%0d win=%b want cnt=2 win=1011", cnt_ovl, win_ovl);
    end else pass_cnt++;
    total_cnt++;
    if (cnt_novl !== 8'd1) begin
      $display("FAIL nonoverlap_count: got %0d want 1", cnt_novl);
    end else pass_cnt++;
  endtask

  task automatic test_gap();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      total_cnt++;
      if (det_ovl !== 1'b0 || win_ovl !== 4'b0010 || cnt_ovl !== 8'd0) begin
        $display("FAIL gap_hold cycle%0d: got det=%b win=%b cnt=%0d want det=0 win=0010 cnt=0",
                 i, det_ovl, win_ovl, cnt_ovl);
      end else pass_cnt++;
    end
    step(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (det_ovl !== 1'b0) begin
      $display("FAIL gap_early: got det=%b want 0", det_ovl);
    end else pass_cnt++;
    step(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (det_ovl !== 1'b1 || cnt_ovl !== 8'd1) begin
      $display("FAIL gap_match: got det=%b cnt=%0d want det=1 cnt=1", det_ovl, cnt_ovl);
    end else pass_cnt++;
    step(1'b0, 1'b0, 1'b0);
    total_cnt++;
    if (det_ovl !== 1'b0) begin
      $display("FAIL gap_pulse_width: got det=%b want 0", det_ovl);
    end else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    rst = 1'b0;
    step(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if (det_ovl !== 1'b0 || win_ovl !== 4'b0001 || cnt_ovl !== 8'd0) begin
      $display("FAIL reset_mid: got det=%b win=%b cnt=%0d want det=0 win=0001 cnt=0",
               det_ovl, win_ovl, cnt_ovl);
    end else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp_ones = 6'b000111;
    logic [3:0] exp_zero = 4'b0001;
    do_reset();
    for (int i = 5; i >= 0; i--) begin
      step(1'b1, 1'b1, 1'b0);
      total_cnt++;
      if (det_ones !== exp_ones[i]) begin
        $display("FAIL ones_detect bit%0d: got %b want %b", 6 - i, det_ones, exp_ones[i]);
      end else pass_cnt++;
    end
    total_cnt++;
    if (cnt_ones !== 8'd3) begin
      $display("FAIL ones_count: got %0d want 3", cnt_ones);
    end else pass_cnt++;
    do_reset();
    for (int i = 3; i >= 0; i--) begin
      step(1'b1, 1'b0, 1'b0);
      total_cnt++;
      if (det_zero !== exp_zero[i]) begin
        $display("FAIL zeros_detect bit%0d: got %b want %b", 4 - i, det_zero, exp_zero[i]);
      end else pass_cnt++;
    end
  endtask

  task automatic test_saturate();
    logic [3:0] pat = 4'b1011;
    logic [1:0] exp_cnt;
    do_reset();
    for (int r = 0; r < 5; r++) begin
      for (int i = 3; i >= 0; i--) step(1'b1, pat[i], 1'b0);
      exp_cnt = (r >= 2) ? 2'd3 : 2'(r + 1);
      total_cnt++;
      if (det_sat !== 1'b1 || cnt_sat2 !== exp_cnt || sat_sat !== (r >= 2)) begin
        $display("FAIL saturate rep%0d: got det=%b cnt=%0d sat=%b want det=1 cnt=%0d sat=%b",
                 r, det_sat, cnt_sat2, sat_sat, exp_cnt, (r >= 2));
      end else pass_cnt++;
    end
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1);
    total_cnt++;
    if (det_sat !== 1'b1 || cnt_sat2 !== 2'd0 || sat_sat !== 1'b0) begin
      $display("FAIL clear_on_match: got det=%b cnt=%0d sat=%b want det=1 cnt=0 sat=0",
               det_sat, cnt_sat2, sat_sat);
    end else pass_cnt++;
    total_cnt++;
    if (win_sat !== 4'b1011) begin
      $display("FAIL clear_keeps_window: got %b want 1011", win_sat);
    end else pass_cnt++;
  endtask

  initial begin
    #1;
    test_reset();
    test_overlap();
    test_gap();
    test_reset_mid();
    test_back_to_back();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
